max6675_emulator: RTL and testbench

Synthesizable responder for the MAX6675 serial thermocouple interface. It is the slave side of the read-only SPI link that our MAX6675 reader drives as master. It answers cs_n/sck with 16-bit MAX6675 frames built from a host-supplied temperature code. It also models conversion timing, so the AC-controller SoC can run hardware-in-the-loop on FPGA and in simulation without a physical sensor.

---
 rtl/max6675_pkg.sv | 30 +++
 rtl/max6675_emulator_sync_edge_det.sv | 41 ++++
 rtl/max6675_emulator.sv | 156 +++++++++++++++
 tb/tb_max6675_emulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/max6675_pkg.sv
// Shared types and frame layout for the MAX6675 sensor emulator.
// Frame: {0, temp[11:0], open, id=0, 0}, shifted out MSB first.
package max6675_pkg;

    typedef enum logic [1:0] {
        CONV  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int FRAME_BITS          = 16;
    localparam int BIT_DUMMY           = 15;
    localparam int TEMP_MSB            = 14;
    localparam int TEMP_LSB            = 3;
    localparam int BIT_OPEN            = 2;
    localparam int BIT_ID              = 1;
    localparam int DEFAULT_CONV_CYCLES = 11_000_000;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [11:0] temp,
                                                          input logic       open_flag);
        logic [FRAME_BITS-1:0] frame;
        frame                    = '0;
        frame[TEMP_MSB:TEMP_LSB] = temp;
        frame[BIT_OPEN]          = open_flag;
        frame[BIT_ID]            = 1'b0;
        frame[BIT_DUMMY]         = 1'b0;
        return frame;
    endfunction

endpackage

// File: rtl/max6675_emulator_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronized value.
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;
    logic              prev_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = din;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/max6675_emulator.sv
// MAX6675 slave emulator: conversion timer plus 16-bit read-only SPI responder.
// Define MAX6675_EMU_FAULT_EN to add inj_xor, XORed into each loaded frame.
import max6675_pkg::*;

module max6675_emulator #(
    parameter int CONV_CYCLES = DEFAULT_CONV_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sck,
    input  logic [11:0] temp_code,
    input  logic        tc_open,
`ifdef MAX6675_EMU_FAULT_EN
    input  logic [15:0] inj_xor,
`endif
    output logic        so,
    output logic        so_en,
    output logic        conv_busy,
    output logic        frame_done,
    output logic        frame_abort
);

    localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      conv_cnt_reg, conv_cnt_next;
    logic [11:0]           result_temp_reg, result_temp_next;
    logic                  result_open_reg, result_open_next;
    logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
    logic [4:0]            bitcnt_reg, bitcnt_next;
    logic                  so_reg, so_next;
    logic                  so_en_reg, so_en_next;
    logic                  done_reg, done_next;
    logic                  abort_reg, abort_next;

    logic                  cs_rise, cs_fall, sck_rise, sck_fall;
    logic                  conv_end;
    logic [FRAME_BITS-1:0] frame_load;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    assign conv_end = (state_reg == CONV) && (conv_cnt_reg == CNT_W'(CONV_CYCLES - 1));

    // The frame is built from the post-update result so a select landing on the
    // conversion-end cycle already sees the fresh reading.
    always_comb begin
        result_temp_next = conv_end ? temp_code : result_temp_reg;
        result_open_next = conv_end ? tc_open   : result_open_reg;
`ifdef MAX6675_EMU_FAULT_EN
        frame_load = build_frame(result_temp_next, result_open_next) ^ inj_xor;
`else
        frame_load = build_frame(result_temp_next, result_open_next);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= CONV;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CONV:    if (cs_fall) state_next = SHIFT; else if (conv_end) state_next = IDLE;
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = CONV;
            default: state_next = CONV;
        endcase
    end

    always_comb begin
        conv_cnt_next = conv_cnt_reg;
        shreg_next    = shreg_reg;
        bitcnt_next   = bitcnt_reg;
        so_next       = so_reg;
        so_en_next    = so_en_reg;
        done_next     = 1'b0;
        abort_next    = 1'b0;
        case (state_reg)
            CONV, IDLE: begin
                if (state_reg == CONV)
                    conv_cnt_next = conv_end ? '0 : conv_cnt_reg + 1'b1;
                if (cs_fall) begin
                    conv_cnt_next = '0;
                    shreg_next    = frame_load;
                    so_next       = frame_load[BIT_DUMMY];
                    so_en_next    = 1'b1;
                    bitcnt_next   = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    so_next       = 1'b0;
                    so_en_next    = 1'b0;
                    done_next     = (bitcnt_reg == 5'(FRAME_BITS));
                    abort_next    = (bitcnt_reg != 5'(FRAME_BITS));
                    conv_cnt_next = '0;
                end else if (sck_fall) begin
                    shreg_next  = {shreg_reg[FRAME_BITS-2:0], 1'b0};
                    so_next     = shreg_reg[FRAME_BITS-2];
                    bitcnt_next = (bitcnt_reg == 5'(FRAME_BITS)) ? bitcnt_reg : bitcnt_reg + 5'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_cnt_reg    <= '0;
            result_temp_reg <= '0;
            result_open_reg <= 1'b0;
            shreg_reg       <= '0;
            bitcnt_reg      <= '0;
            so_reg          <= 1'b0;
            so_en_reg       <= 1'b0;
            done_reg        <= 1'b0;
            abort_reg       <= 1'b0;
        end else begin
            conv_cnt_reg    <= conv_cnt_next;
            result_temp_reg <= result_temp_next;
            result_open_reg <= result_open_next;
            shreg_reg       <= shreg_next;
            bitcnt_reg      <= bitcnt_next;
            so_reg          <= so_next;
            so_en_reg       <= so_en_next;
            done_reg        <= done_next;
            abort_reg       <= abort_next;
        end
    end

    always_comb begin
        conv_busy   = (state_reg == CONV);
        so          = so_reg;
        so_en       = so_en_reg;
        frame_done  = done_reg;
        frame_abort = abort_reg;
    end

endmodule

// File: tb/tb_max6675_emulator.sv
// Directed bench for max6675_emulator: table of conversion/read vectors plus
// hand sequences for stale reads, aborts, over-clocking and mid-frame reset.
module tb_max6675_emulator;

    localparam int H = 6;

`ifdef MAX6675_EMU_FAULT_EN
    localparam logic [15:0] INJ = 16'h0002;
`else
    localparam logic [15:0] INJ = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic [11:0] temp_code = 12'h190;
    logic        tc_open = 1'b0;
    logic        so, so_en, conv_busy, frame_done, frame_abort;

    int total = 0;
    int passed = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    always #5 clk = ~clk;

    max6675_emulator #(.CONV_CYCLES(100), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs_n        (cs_n),
        .sck         (sck),
        .temp_code   (temp_code),
        .tc_open     (tc_open),
`ifdef MAX6675_EMU_FAULT_EN
        .inj_xor     (INJ),
`endif
        .so          (so),
        .so_en       (so_en),
        .conv_busy   (conv_busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always @(posedge clk) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    typedef struct {
        logic [11:0] temp;
        logic        open_flag;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input int n, output logic [31:0] d);
        d = '0;
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            cycles(H);
            d = {d[30:0], so};
            if (i == 0) check("so_en_during_frame", {31'd0, so_en}, 32'd1);
            sck = 1'b0;
            cycles(H);
        end
    endtask

    task automatic read_check(input string name, input int n, input logic [31:0] exp);
        int          d0, a0;
        logic [31:0] d;
        d0 = done_cnt;
        a0 = abort_cnt;
        cs_n = 1'b0;
        cycles(H);
        shift_bits(n, d);
        cs_n = 1'b1;
        cycles(8);
        $display("read %s: %0d bits = %h", name, n, d);
        check(name, d, exp);
        check({name, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_noabort"}, 32'(abort_cnt - a0), 32'd0);
        check({name, "_so_en_off"}, {31'd0, so_en}, 32'd0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (conv_busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("conv_complete", {31'd0, conv_busy}, 32'd0);
    endtask

    task automatic measure_busy(output int len);
        len = 0;
        while (conv_busy && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          len, k, a0, d0;

        vecs[0] = '{12'h190, 1'b0, 16'h0C80};
        vecs[1] = '{12'hFFF, 1'b1, 16'h7FFC};
        vecs[2] = '{12'h000, 1'b0, 16'h0000};
        vecs[3] = '{12'h000, 1'b1, 16'h0004};
        vecs[4] = '{12'hA5A, 1'b0, 16'h52D0};
        vecs[5] = '{12'h001, 1'b0, 16'h0008};

        // Reset state
        cycles(5);
        check("rst_so", {31'd0, so}, 32'd0);
        check("rst_so_en", {31'd0, so_en}, 32'd0);
        check("rst_busy", {31'd0, conv_busy}, 32'd1);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_abort", {31'd0, frame_abort}, 32'd0);
        rst = 1'b0;
        measure_busy(len);
        check("first_conv_len", 32'(len), 32'd100);

        // Table: each vector converts fully, then is read back
        for (int i = 0; i < 6; i++) begin
            temp_code = vecs[i].temp;
            tc_open   = vecs[i].open_flag;
            wait_idle();
            read_check($sformatf("vec%0d", i), 16, {16'd0, vecs[i].frame ^ INJ});
        end

        // Read before the new conversion completes returns the previous result
        temp_code = 12'h123;
        tc_open   = 1'b0;
        read_check("stale_read", 16, {16'd0, vecs[5].frame ^ INJ});
        wait_idle();
        read_check("fresh_read", 16, {16'd0, 16'h0918 ^ INJ});

        // Select around conversion cycle 50 aborts it; result stays old
        temp_code = 12'h2AB;
        cycles(42);
        check("busy_before_abort", {31'd0, conv_busy}, 32'd1);
        d0 = done_cnt;
        cs_n = 1'b0;
        cycles(H);
        check("busy_after_abort", {31'd0, conv_busy}, 32'd0);
        shift_bits(16, d);
        $display("read abort_conv: 16 bits = %h", d);
        check("abort_conv_read", d, {16'd0, 16'h0918 ^ INJ});
        cs_n = 1'b1;
        k = 0;
        while (!conv_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("busy_reasserts", {31'd0, conv_busy}, 32'd1);
        measure_busy(len);
        check("restart_conv_len", 32'(len), 32'd100);
        check("abort_conv_done", 32'(done_cnt - d0), 32'd1);
        read_check("after_abort_conv", 16, {16'd0, 16'h1558 ^ INJ});

        // Short frame: 7 falls then deselect
        a0 = abort_cnt;
        d0 = done_cnt;
        wait_idle();
        cs_n = 1'b0;
        cycles(H);
        shift_bits(7, d);
        cs_n = 1'b1;
        cycles(8);
        $display("read short: 7 bits = %h", d);
        check("short_bits", d, 32'((16'h1558 ^ INJ) >> 9));
        check("short_abort", 32'(abort_cnt - a0), 32'd1);
        check("short_nodone", 32'(done_cnt - d0), 32'd0);
        check("short_so_en", {31'd0, so_en}, 32'd0);
        temp_code = 12'h3C7;
        tc_open   = 1'b1;
        wait_idle();
        read_check("after_short", 16, {16'd0, 16'h1E3C ^ INJ});

        // Over-clocked frame: bits 16..19 read as zero
        wait_idle();
        read_check("long20", 20, {12'd0, 16'h1E3C ^ INJ, 4'h0});

        // Reset mid-frame after 5 bits
        temp_code = 12'h064;
        tc_open   = 1'b0;
        wait_idle();
        cs_n = 1'b0;
        cycles(H);
        shift_bits(5, d);
        rst = 1'b1;
        cycles(1);
        check("midrst_so", {31'd0, so}, 32'd0);
        check("midrst_so_en", {31'd0, so_en}, 32'd0);
        check("midrst_busy", {31'd0, conv_busy}, 32'd1);
        check("midrst_done", {31'd0, frame_done}, 32'd0);
        check("midrst_abort", {31'd0, frame_abort}, 32'd0);
        cs_n = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(2);
        read_check("post_rst_zero", 16, {16'd0, INJ});
        wait_idle();
        read_check("post_rst_new", 16, {16'd0, 16'h0320 ^ INJ});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
